ps2_scancode_decoder: RTL and testbench

Turns the raw byte stream from the PS/2 receiver (`slave2_PS2`: `data_valid`, `data_out[7:0]`) into whole key events. It strips the set-2 prefixes `E0`, `F0` and `E1` and flags keyboard housekeeping bytes. Events are buffered in a small FIFO behind a valid/ready handshake. It sits between the PS/2 receiver and the display/consumer logic, which sees one 10-bit word per key press or release instead of raw bytes.

---
 rtl/ps2_scancode_decoder_pkg.sv | 40 ++++
 rtl/ps2_scancode_decoder_if.sv | 21 ++
 rtl/ps2_scancode_decoder_fifo.sv | 49 ++++
 rtl/ps2_scancode_decoder.sv | 110 +++++++++++
 tb/tb_ps2_scancode_decoder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared constants for the PS/2 set-2 scan code decoder: prefix bytes,
// FSM encodings and the 10-bit event word layout.
package ps2_scancode_decoder_pkg;
  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_FE = 8'hFE;
  localparam logic [7:0] B_EE = 8'hEE;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_E0    = 3'd1;
  localparam logic [2:0] ST_F0    = 3'd2;
  localparam logic [2:0] ST_E0F0  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  // Bytes following E1 in the pause sequence that are swallowed.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int EV_W        = 10;
  localparam int EV_CODE_LSB = 0;
  localparam int EV_REL_BIT  = 8;
  localparam int EV_EXT_BIT  = 9;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ev_t;

  function automatic logic is_housekeeping(input logic [7:0] b);
    return (b == B_AA) || (b == B_FA) || (b == B_FE) || (b == B_EE) ||
           (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == 8'h12) || (b == 8'h59);
  endfunction
endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / event-out bundle of the scan code decoder.
interface ps2_scancode_decoder_if;
  logic       data_valid;
  logic [7:0] data_in;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_release;
  logic       ev_extended;
  logic       overflow;
  logic       busy;

  modport slave (
    input  data_valid, data_in, ev_ready,
    output ev_valid, ev_code, ev_release, ev_extended, overflow, busy
  );
  modport master (
    output data_valid, data_in, ev_ready,
    input  ev_valid, ev_code, ev_release, ev_extended, overflow, busy
  );
endinterface

// File: rtl/ps2_scancode_decoder_fifo.sv
// First-word-fall-through event FIFO; storage is cleared on reset so the
// head reads zero afterwards.
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic                    do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// Collapses raw PS/2 set-2 bytes into {ext, rel, code} key events queued
// behind a valid/ready handshake.
module ps2_scancode_decoder
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ps2_scancode_decoder_if.slave bus
);
  logic       dv_q;
  logic       accept;
  logic [2:0] state, state_nxt;
  logic [2:0] skip, skip_nxt;
  logic       push, pop, full, empty;
  logic       ovf;
  ev_t        word, head;
  logic [7:0] b;

  assign b      = bus.data_in;
  assign accept = bus.data_valid && !dv_q;
  assign pop    = bus.ev_ready && !empty;

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    push      = 1'b0;
    word      = '0;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (b == B_E0) state_nxt = ST_E0;
          else if (b == B_F0) state_nxt = ST_F0;
          else if (b == B_E1) begin
            state_nxt = ST_PAUSE;
            skip_nxt  = PAUSE_SKIP;
          end else if (!is_housekeeping(b)) begin
            push = 1'b1;
            word = '{ext: 1'b0, rel: 1'b0, code: b};
          end
        end
        ST_F0: begin
          push      = 1'b1;
          word      = '{ext: 1'b0, rel: 1'b1, code: b};
          state_nxt = ST_IDLE;
        end
        ST_E0: begin
          if (b == B_F0) state_nxt = ST_E0F0;
          else begin
            state_nxt = ST_IDLE;
            if (!is_fake_shift(b)) begin
              push = 1'b1;
              word = '{ext: 1'b1, rel: 1'b0, code: b};
            end
          end
        end
        ST_E0F0: begin
          state_nxt = ST_IDLE;
          if (!is_fake_shift(b)) begin
            push = 1'b1;
            word = '{ext: 1'b1, rel: 1'b1, code: b};
          end
        end
        ST_PAUSE: begin
          skip_nxt = skip - 1'b1;
          // The whole pause sequence is reported as a single E1 make.
          if (skip <= 3'd1) begin
            state_nxt = ST_IDLE;
            push      = 1'b1;
            word      = '{ext: 1'b1, rel: 1'b0, code: B_E1};
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q  <= 1'b0;
      state <= ST_IDLE;
      skip  <= '0;
      ovf   <= 1'b0;
    end else begin
      dv_q  <= bus.data_valid;
      state <= state_nxt;
      skip  <= skip_nxt;
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  ps2_event_fifo #(.DEPTH(DEPTH), .W(EV_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (word),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign bus.ev_valid    = !empty;
  assign bus.ev_code     = head.code;
  assign bus.ev_release  = head.rel;
  assign bus.ev_extended = head.ext;
  assign bus.overflow    = ovf;
  assign bus.busy        = (state != ST_IDLE);
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for the scan code decoder; inputs change and outputs are
// sampled on the falling edge.
module tb_ps2_scancode_decoder;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  ps2_scancode_decoder_if bus();

  ps2_scancode_decoder #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] head();
    return {bus.ev_extended, bus.ev_release, bus.ev_code};
  endfunction

  // One-cycle strobe; the byte is accepted on the single rising edge inside.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.data_valid = 1'b1;
    bus.data_in    = b;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [9:0] exp);
    chk({tag, "_v"}, 32'(bus.ev_valid), 32'd1);
    chk({tag, "_w"}, 32'(head()), 32'(exp));
    bus.ev_ready = 1'b1;
    @(negedge clk);
    bus.ev_ready = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v"},   32'(bus.ev_valid), 32'd0);
    chk({tag, "_w"},   32'(head()), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    chk({tag, "_bsy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    bus.ev_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // make then break with the consumer always ready
    bus.ev_ready = 1'b1;
    send(8'h1C);
    chk("mk_1c", 32'(head()), 32'h01C);
    chk("mk_1c_v", 32'(bus.ev_valid), 32'd1);
    send(8'hF0);
    chk("f0_busy", 32'(bus.busy), 32'd1);
    chk("f0_nov", 32'(bus.ev_valid), 32'd0);
    send(8'h1C);
    chk("brk_1c", 32'(head()), 32'h11C);
    chk("brk_1c_v", 32'(bus.ev_valid), 32'd1);
    @(negedge clk);
    chk("t1_empty", 32'(bus.ev_valid), 32'd0);
    bus.ev_ready = 1'b0;

    // extended keys with housekeeping bytes around them
    send(8'hAA);
    chk("aa_drop", 32'(bus.ev_valid), 32'd0);
    send(8'hE0);
    chk("e0_busy", 32'(bus.busy), 32'd1);
    send(8'h75);
    chk("e0_idle", 32'(bus.busy), 32'd0);
    send(8'hFA);
    send(8'hE0);
    send(8'hF0);
    chk("e0f0_busy", 32'(bus.busy), 32'd1);
    send(8'h75);
    pop_chk("e0_mk", 10'h275);
    pop_chk("e0_brk", 10'h375);
    chk("t2_empty", 32'(bus.ev_valid), 32'd0);

    // print screen: fake shift is dropped
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
    pop_chk("prtsc", 10'h27C);
    chk("prtsc_empty", 32'(bus.ev_valid), 32'd0);

    // pause: eight bytes, one event
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("pause_busy", 32'(bus.busy), 32'd1);
    chk("pause_nov", 32'(bus.ev_valid), 32'd0);
    send(8'h77);
    chk("pause_idle", 32'(bus.busy), 32'd0);
    pop_chk("pause", 10'h2E1);
    chk("pause_empty", 32'(bus.ev_valid), 32'd0);

    // overflow with the consumer stalled
    for (int i = 1; i <= 4; i++) send(8'(i));
    chk("ovf_pre", 32'(bus.overflow), 32'd0);
    send(8'h05);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    bus.ev_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_pop%0d", i), 32'(head()), 32'(i));
      @(negedge clk);
    end
    bus.ev_ready = 1'b0;
    chk("ovf_drain", 32'(bus.ev_valid), 32'd0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ovf_clr", 32'(bus.overflow), 32'd0);

    // simultaneous push and pop while full
    for (int i = 1; i <= 4; i++) send(8'(i));
    @(negedge clk);
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h06;
    bus.ev_ready   = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    bus.ev_ready   = 1'b0;
    chk("pp_ovf", 32'(bus.overflow), 32'd0);
    pop_chk("pp_02", 10'h002);
    pop_chk("pp_03", 10'h003);
    pop_chk("pp_04", 10'h004);
    pop_chk("pp_06", 10'h006);
    chk("pp_empty", 32'(bus.ev_valid), 32'd0);

    // reset mid-prefix, and a byte in the reset cycle
    send(8'h33);
    send(8'hE0);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_rst");
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h44;
    @(negedge clk);
    bus.data_valid = 1'b0;
    rst = 1'b0;
    chk("rst_byte", 32'(bus.ev_valid), 32'd0);
    send(8'h75);
    pop_chk("post_rst", 10'h075);
    chk("post_rst_empty", 32'(bus.ev_valid), 32'd0);

    // held-high strobe gives one byte
    @(negedge clk);
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h2A;
    repeat (5) @(negedge clk);
    bus.data_valid = 1'b0;
    pop_chk("held", 10'h02A);
    chk("held_once", 32'(bus.ev_valid), 32'd0);
    @(negedge clk);
    chk("held_once2", 32'(bus.ev_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
